fifo_syn_flex: RTL and testbench

Parametrised synchronous FIFO; next generation of the team's single-clock fifo_syn.
Adds configurable width, depth and almost-full/almost-empty thresholds, plus an occupancy count and error flags.
Adds a selectable first-word-fall-through (FWFT) read mode.
Sits between a producer and a consumer in the same clock domain as a rate-smoothing buffer.

---
 rtl/fifo_syn_flex_if.sv | 30 +++
 rtl/fifo_syn_flex.sv | 97 +++++++++
 tb/tb_fifo_syn_flex.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_syn_flex_if.sv
// Handshake bundle between a producer/consumer pair and fifo_syn_flex.
// The master side drives requests and write data; the slave side is the FIFO.
interface fifo_syn_flex_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             wr;
  logic             rd;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] q;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr, rd, data,
    input  q, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr, rd, data,
    output q, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_syn_flex.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// overflow/underflow pulses and an optional first-word-fall-through read port.
module fifo_syn_flex #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input logic            clk,
  input logic            rst,
  fifo_syn_flex_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_C  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_C = (AW+1)'(AEMPTY_TH);
  localparam logic [AW:0] ONE_C    = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             full;
  logic             empty;
  logic             wr_ok;
  logic             rd_ok;
  logic [WIDTH-1:0] head;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign head  = mem[rd_ptr_q[AW-1:0]];

  // A write into a full FIFO is still taken when a read frees the slot in the same edge.
  assign wr_ok = bus.wr & (~full | bus.rd);
  assign rd_ok = bus.rd & ~empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    q_d         = q_q;
    overflow_d  = bus.wr & full & ~bus.rd;
    underflow_d = bus.rd & empty;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + ONE_C;
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + ONE_C;
      q_d      = head;
    end
    if (wr_ok & ~rd_ok) begin
      count_d = count_q + ONE_C;
    end else if (rd_ok & ~wr_ok) begin
      count_d = count_q - ONE_C;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      q_q         <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      q_q         <= q_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never cleared; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wr_ptr_q[AW-1:0]] <= bus.data;
    end
  end

  assign bus.q            = (FWFT != 0) ? (empty ? '0 : head) : q_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AFULL_C);
  assign bus.almost_empty = (count_q <= AEMPTY_C);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_syn_flex.sv
// Directed bench for fifo_syn_flex: a standard-read instance driven from a vector
// table plus hand sequences for wrap-around and a FWFT instance with mid-run reset.
module tb_fifo_syn_flex;
  logic clk;
  logic rst;

  int compared;
  int mismatched;

  typedef struct {
    string      name;
    logic       wr;
    logic       rd;
    logic [7:0] data;
    logic [7:0] exp_q;
    int         exp_count;
    logic       exp_ovf;
    logic       exp_udf;
  } vec_t;

  vec_t vecs[$];

  fifo_syn_flex_if #(.WIDTH(8), .DEPTH(8)) bus0 ();
  fifo_syn_flex_if #(.WIDTH(8), .DEPTH(8)) bus1 ();

  fifo_syn_flex #(.WIDTH(8), .DEPTH(8), .FWFT(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  fifo_syn_flex #(.WIDTH(8), .DEPTH(8), .FWFT(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input string name, input logic wr, input logic rd,
                        input logic [7:0] data, input logic [7:0] exp_q,
                        input int exp_count, input logic exp_ovf, input logic exp_udf);
    vec_t v;
    v.name      = name;
    v.wr        = wr;
    v.rd        = rd;
    v.data      = data;
    v.exp_q     = exp_q;
    v.exp_count = exp_count;
    v.exp_ovf   = exp_ovf;
    v.exp_udf   = exp_udf;
    vecs.push_back(v);
  endtask

  task automatic compareVal(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one bus for a single rising edge, then settle just past the edge.
  task automatic applyStimulus(input int sel, input logic wr, input logic rd, input logic [7:0] data);
    bus0.wr = 1'b0; bus0.rd = 1'b0; bus0.data = 8'h00;
    bus1.wr = 1'b0; bus1.rd = 1'b0; bus1.data = 8'h00;
    if (sel == 0) begin
      bus0.wr = wr; bus0.rd = rd; bus0.data = data;
    end else begin
      bus1.wr = wr; bus1.rd = rd; bus1.data = data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int sel, input logic [7:0] exp_q,
                             input int exp_count, input logic exp_ovf, input logic exp_udf);
    logic [7:0] aq;
    logic [3:0] ac;
    logic       af, ae, aaf, aae, ao, au;
    if (sel == 0) begin
      aq = bus0.q; ac = bus0.count; af = bus0.full; ae = bus0.empty;
      aaf = bus0.almost_full; aae = bus0.almost_empty; ao = bus0.overflow; au = bus0.underflow;
    end else begin
      aq = bus1.q; ac = bus1.count; af = bus1.full; ae = bus1.empty;
      aaf = bus1.almost_full; aae = bus1.almost_empty; ao = bus1.overflow; au = bus1.underflow;
    end
    compareVal({name, ".q"}, int'(aq), int'(exp_q));
    compareVal({name, ".count"}, int'(ac), exp_count);
    compareVal({name, ".full"}, int'(af), (exp_count == 8) ? 1 : 0);
    compareVal({name, ".empty"}, int'(ae), (exp_count == 0) ? 1 : 0);
    compareVal({name, ".almost_full"}, int'(aaf), (exp_count >= 6) ? 1 : 0);
    compareVal({name, ".almost_empty"}, int'(aae), (exp_count <= 2) ? 1 : 0);
    compareVal({name, ".overflow"}, int'(ao), int'(exp_ovf));
    compareVal({name, ".underflow"}, int'(au), int'(exp_udf));
  endtask

  initial begin
    logic [7:0] fill_pat [8];
    logic [7:0] k;
    compared   = 0;
    mismatched = 0;

    fill_pat[0] = 8'hab; fill_pat[1] = 8'h12; fill_pat[2] = 8'h34; fill_pat[3] = 8'h56;
    fill_pat[4] = 8'h78; fill_pat[5] = 8'hcd; fill_pat[6] = 8'hcc; fill_pat[7] = 8'hdd;

    // Standard-read instance: fill, overflow, drain, underflow, full and empty simultaneous access.
    for (int i = 0; i < 8; i++)
      addVec($sformatf("fill%0d", i), 1'b1, 1'b0, fill_pat[i], 8'h00, i + 1, 1'b0, 1'b0);
    addVec("overflow", 1'b1, 1'b0, 8'hee, 8'h00, 8, 1'b1, 1'b0);
    addVec("ovf_clear", 1'b0, 1'b0, 8'h00, 8'h00, 8, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      addVec($sformatf("drain%0d", i), 1'b0, 1'b1, 8'h00, fill_pat[i], 7 - i, 1'b0, 1'b0);
    addVec("underflow", 1'b0, 1'b1, 8'h00, 8'hdd, 0, 1'b0, 1'b1);
    addVec("udf_clear", 1'b0, 1'b0, 8'h00, 8'hdd, 0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      addVec($sformatf("refill%0d", i), 1'b1, 1'b0, 8'(i + 1), 8'hdd, i + 1, 1'b0, 1'b0);
    addVec("full_wr_rd", 1'b1, 1'b1, 8'hee, 8'h01, 8, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++)
      addVec($sformatf("redrain%0d", i), 1'b0, 1'b1, 8'h00, 8'(i + 2), 7 - i, 1'b0, 1'b0);
    addVec("redrain_ee", 1'b0, 1'b1, 8'h00, 8'hee, 0, 1'b0, 1'b0);
    addVec("empty_wr_rd", 1'b1, 1'b1, 8'h5a, 8'hee, 1, 1'b0, 1'b1);
    addVec("read_5a", 1'b0, 1'b1, 8'h00, 8'h5a, 0, 1'b0, 1'b0);

    rst = 1'b1;
    bus0.wr = 1'b0; bus0.rd = 1'b0; bus0.data = 8'h00;
    bus1.wr = 1'b0; bus1.rd = 1'b0; bus1.data = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset0", 0, 8'h00, 0, 1'b0, 1'b0);
    checkOutput("reset1", 1, 8'h00, 0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      applyStimulus(0, vecs[i].wr, vecs[i].rd, vecs[i].data);
      checkOutput(vecs[i].name, 0, vecs[i].exp_q, vecs[i].exp_count, vecs[i].exp_ovf, vecs[i].exp_udf);
    end

    // Overlapped write/read stream across several pointer wraps.
    applyStimulus(0, 1'b1, 1'b0, 8'h00);
    checkOutput("wrap_start", 0, 8'h5a, 1, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) begin
      k = 8'(i);
      applyStimulus(0, 1'b1, 1'b1, k);
      checkOutput($sformatf("wrap%0d", i), 0, k - 8'h01, 1, 1'b0, 1'b0);
    end
    applyStimulus(0, 1'b0, 1'b1, 8'h00);
    checkOutput("wrap_end", 0, 8'h13, 0, 1'b0, 1'b0);

    // FWFT instance: fall-through, pop, ordering, empty wr+rd, reset mid-operation.
    applyStimulus(1, 1'b1, 1'b0, 8'h3c);
    checkOutput("fwft_fall", 1, 8'h3c, 1, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 8'h00);
    checkOutput("fwft_hold", 1, 8'h3c, 1, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b1, 8'h00);
    checkOutput("fwft_pop", 1, 8'h00, 0, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 1'b1, 8'h77);
    checkOutput("fwft_empty_wr_rd", 1, 8'h77, 1, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 1'b1, 8'h00);
    checkOutput("fwft_pop77", 1, 8'h00, 0, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 8'ha1);
    checkOutput("fwft_w1", 1, 8'ha1, 1, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 8'hb2);
    checkOutput("fwft_w2", 1, 8'ha1, 2, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 8'hc3);
    checkOutput("fwft_w3", 1, 8'ha1, 3, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b1, 8'h00);
    checkOutput("fwft_next", 1, 8'hb2, 2, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1, 1'b1, 1'b0, 8'hdd);
    rst = 1'b0;
    checkOutput("fwft_reset", 1, 8'h00, 0, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b1, 8'h00);
    checkOutput("fwft_underflow", 1, 8'h00, 0, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 1'b0, 8'h00);
    checkOutput("fwft_udf_clear", 1, 8'h00, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
